ex_issue: RTL and testbench

EX_ISSUE -- requirements
Module: ex_issue

---
 rtl/ex_issue.sv | 135 +++++++++++++
 tb/tb_ex_issue.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_issue.sv
// Execute issue stage: latches one operation, drives the ALU, holds the result for writeback.
// Optional watchdog on a stalled ALU when EX_TIMEOUT_EN is defined.
module ex_issue #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data1_i,
  input  logic [31:0] in_data2_i,
  input  logic [3:0]  in_op_i,
  input  logic [4:0]  in_rd_i,
  output logic [31:0] ALU_data1_o,
  output logic [31:0] ALU_data2_o,
  output logic [3:0]  ALU_op_o,
  input  logic [31:0] ALU_result_i,
  input  logic        ALU_busy_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_result_o,
  output logic [4:0]  out_rd_o,
  output logic        out_err_o
);

  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam logic [3:0]  ALU_ADD   = 4'h0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("ex_issue: TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]  state_q;
  logic [31:0] data1_q;
  logic [31:0] data2_q;
  logic [3:0]  op_q;
  logic [4:0]  rd_q;
  logic [31:0] result_q;
  logic        err_q;
  logic        accept;
  logic        expire;

  assign in_ready_o  = (state_q == S_IDLE) |
                       ((state_q == S_DONE) & out_ready_i);
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = (state_q == S_DONE);

  assign ALU_data1_o  = data1_q;
  assign ALU_data2_o  = data2_q;
  assign ALU_op_o     = op_q;
  assign out_result_o = result_q;
  assign out_rd_o     = rd_q;

`ifdef EX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt_q;

  assign expire = (state_q == S_WAIT) & ALU_busy_i &
                  (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign out_err_o = err_q;

  // WAIT is only ever entered from ISSUE, so clearing there is entry-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else if (state_q == S_ISSUE) begin
      wd_cnt_q <= '0;
    end else if ((state_q == S_WAIT) & ALU_busy_i & ~expire) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end
`else
  assign expire    = 1'b0;
  assign out_err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= ZERO_WORD;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!ALU_busy_i) begin
            result_q <= ALU_result_i;
            err_q    <= 1'b0;
            state_q  <= S_DONE;
          end else begin
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!ALU_busy_i) begin
            result_q <= ALU_result_i;
            err_q    <= 1'b0;
            state_q  <= S_DONE;
          end else if (expire) begin
            result_q <= ZERO_WORD;
            err_q    <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready_i) state_q <= accept ? S_ISSUE : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data1_q <= ZERO_WORD;
      data2_q <= ZERO_WORD;
      op_q    <= ALU_ADD;
      rd_q    <= 5'd0;
    end else if (accept) begin
      data1_q <= in_data1_i;
      data2_q <= in_data2_i;
      op_q    <= in_op_i;
      rd_q    <= in_rd_i;
    end
  end

endmodule

// File: tb/tb_ex_issue.sv
// Self-checking bench for ex_issue: directed scenarios plus randomized
// traffic against a transaction-level model; the bench plays the ALU.
module tb_ex_issue;

  localparam int TO = 4;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_OR  = 4'h3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data1_i;
  logic [31:0] in_data2_i;
  logic [3:0]  in_op_i;
  logic [4:0]  in_rd_i;
  logic [31:0] ALU_data1_o;
  logic [31:0] ALU_data2_o;
  logic [3:0]  ALU_op_o;
  logic [31:0] ALU_result_i;
  logic        ALU_busy_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_result_o;
  logic [4:0]  out_rd_o;
  logic        out_err_o;
  logic [31:0] junk;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_issue #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data1_i(in_data1_i), .in_data2_i(in_data2_i),
    .in_op_i(in_op_i), .in_rd_i(in_rd_i),
    .ALU_data1_o(ALU_data1_o), .ALU_data2_o(ALU_data2_o),
    .ALU_op_o(ALU_op_o), .ALU_result_i(ALU_result_i),
    .ALU_busy_i(ALU_busy_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_result_o(out_result_o),
    .out_rd_o(out_rd_o), .out_err_o(out_err_o)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a & b;
      4'h3:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // garbage on the result bus while busy exposes captures taken too early
  assign ALU_result_i = ALU_busy_i ? junk
                      : ref_alu(ALU_op_o, ALU_data1_o, ALU_data2_o);

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    ALU_busy_i  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    in_valid_i  = 1'b1;
    in_data1_i  = 32'h1234_5678;
    in_data2_i  = 32'h0BAD_F00D;
    in_op_i     = 4'h2;
    in_rd_i     = 5'd17;
    ALU_busy_i  = 1'b0;
    out_ready_i = 1'b1;
    junk        = 32'hA5A5_A5A5;
    repeat (3) step();
    total++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_hs got valid=%0b ready=%0b want 0/1",
               out_valid_o, in_ready_o);
    end
    total++;
    if (out_result_o !== 32'h0 || out_rd_o !== 5'd0 || out_err_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_out got res=%h rd=%0d err=%0b want 0/0/0",
               out_result_o, out_rd_o, out_err_o);
    end
    total++;
    if (ALU_data1_o !== 32'h0 || ALU_data2_o !== 32'h0 || ALU_op_o !== OP_ADD) begin
      bad++;
      $display("FAIL reset_alu got d1=%h d2=%h op=%h want 0/0/0",
               ALU_data1_o, ALU_data2_o, ALU_op_o);
    end
    idle_inputs();
    rst_n = 1'b1;
    step();
    total++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got ready=%0b valid=%0b want 1/0",
               in_ready_o, out_valid_o);
    end
  endtask

  task automatic test_basic;
    in_valid_i = 1'b1;
    in_data1_i = 32'd5;
    in_data2_i = 32'd3;
    in_op_i    = OP_ADD;
    in_rd_i    = 5'd7;
    #1;
    total++;
    if (in_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL basic_ready got=%0b want=1", in_ready_o);
    end
    step();
    in_valid_i = 1'b0;
    total++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_issue got valid=%0b ready=%0b want 0/0",
               out_valid_o, in_ready_o);
    end
    total++;
    if (ALU_data1_o !== 32'd5 || ALU_data2_o !== 32'd3 || ALU_op_o !== OP_ADD) begin
      bad++;
      $display("FAIL basic_alu got d1=%0d d2=%0d op=%0d want 5/3/0",
               ALU_data1_o, ALU_data2_o, ALU_op_o);
    end
    step();
    total++;
    if (out_valid_o !== 1'b1 || out_result_o !== 32'd8 ||
        out_rd_o !== 5'd7 || out_err_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_result got v=%0b res=%0d rd=%0d err=%0b want 1/8/7/0",
               out_valid_o, out_result_o, out_rd_o, out_err_o);
    end
    step();
    total++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL basic_idle got valid=%0b ready=%0b want 0/1",
               out_valid_o, in_ready_o);
    end
  endtask

  task automatic test_wait;
    in_valid_i = 1'b1;
    in_data1_i = 32'd10;
    in_data2_i = 32'd4;
    in_op_i    = OP_SUB;
    in_rd_i    = 5'd12;
    ALU_busy_i = 1'b1;
    junk       = 32'hDEAD_BEEF;
    step();
    in_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (out_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL wait_busy%0d got valid=%0b want=0", k, out_valid_o);
      end
      if (k < 2) step();
    end
    ALU_busy_i = 1'b0;
    step();
    total++;
    if (out_valid_o !== 1'b1 || out_result_o !== 32'd6 ||
        out_rd_o !== 5'd12 || out_err_o !== 1'b0) begin
      bad++;
      $display("FAIL wait_result got v=%0b res=%0d rd=%0d err=%0b want 1/6/12/0",
               out_valid_o, out_result_o, out_rd_o, out_err_o);
    end
    step();
  endtask

  task automatic test_stall;
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data1_i  = 32'd21;
    in_data2_i  = 32'd2;
    in_op_i     = OP_OR;
    in_rd_i     = 5'd3;
    step();
    in_data1_i = 32'd100;
    in_data2_i = 32'd30;
    in_op_i    = OP_SUB;
    in_rd_i    = 5'd9;
    step();
    for (int k = 0; k < 5; k++) begin
      ALU_busy_i = k[0];
      #1;
      total++;
      if (out_valid_o !== 1'b1 || out_result_o !== 32'd23 ||
          out_rd_o !== 5'd3 || in_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d got v=%0b res=%0d rd=%0d rdy=%0b want 1/23/3/0",
                 k, out_valid_o, out_result_o, out_rd_o, in_ready_o);
      end
      step();
    end
    ALU_busy_i  = 1'b0;
    out_ready_i = 1'b1;
    #1;
    total++;
    if (in_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL stall_release_ready got=%0b want=1", in_ready_o);
    end
    step();
    in_valid_i = 1'b0;
    total++;
    if (out_valid_o !== 1'b0 || ALU_data1_o !== 32'd100 || ALU_op_o !== OP_SUB) begin
      bad++;
      $display("FAIL stall_b2b_issue got v=%0b d1=%0d op=%0d want 0/100/1",
               out_valid_o, ALU_data1_o, ALU_op_o);
    end
    step();
    total++;
    if (out_valid_o !== 1'b1 || out_result_o !== 32'd70 || out_rd_o !== 5'd9) begin
      bad++;
      $display("FAIL stall_b2b_result got v=%0b res=%0d rd=%0d want 1/70/9",
               out_valid_o, out_result_o, out_rd_o);
    end
    step();
  endtask

  task automatic test_reset_mid;
    bit seen = 1'b0;
    in_valid_i = 1'b1;
    in_data1_i = 32'd50;
    in_data2_i = 32'd1;
    in_op_i    = OP_ADD;
    in_rd_i    = 5'd4;
    ALU_busy_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || out_result_o !== 32'h0) begin
      bad++;
      $display("FAIL rstmid_async got v=%0b rdy=%0b res=%h want 0/1/0",
               out_valid_o, in_ready_o, out_result_o);
    end
    ALU_busy_i = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (in_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_ready got=%0b want=1", in_ready_o);
    end
    for (int k = 0; k < 6; k++) begin
      if (out_valid_o === 1'b1) seen = 1'b1;
      step();
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL rstmid_no_output got valid seen=1 want 0");
    end
  endtask

  task automatic test_timeout;
`ifdef EX_TIMEOUT_EN
    for (int run = 0; run < 2; run++) begin
      in_valid_i = 1'b1;
      in_data1_i = 32'd9;
      in_data2_i = 32'd9;
      in_op_i    = OP_ADD;
      in_rd_i    = 5'd1;
      ALU_busy_i = 1'b1;
      step();
      in_valid_i = 1'b0;
      step();
      for (int k = 0; k < TO; k++) begin
        total++;
        if (out_valid_o !== 1'b0) begin
          bad++;
          $display("FAIL timeout_wait%0d_%0d got valid=1 want 0", run, k);
        end
        if (k < TO - 1) step();
      end
      if (run == 1) ALU_busy_i = 1'b0;
      step();
      total++;
      if (out_valid_o !== 1'b1 ||
          out_result_o !== (run == 0 ? 32'd0 : 32'd18) ||
          out_err_o !== (run == 0)) begin
        bad++;
        $display("FAIL timeout_result%0d got v=%0b res=%0d err=%0b",
                 run, out_valid_o, out_result_o, out_err_o);
      end
      ALU_busy_i = 1'b0;
      step();
    end
`else
    bit seen = 1'b0;
    in_valid_i = 1'b1;
    in_data1_i = 32'd9;
    in_data2_i = 32'd9;
    in_op_i    = OP_ADD;
    in_rd_i    = 5'd1;
    ALU_busy_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid_o === 1'b1 || out_err_o !== 1'b0) seen = 1'b1;
      step();
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL wait_forever got early output or err want none");
    end
    ALU_busy_i = 1'b0;
    step();
    total++;
    if (out_valid_o !== 1'b1 || out_result_o !== 32'd18 || out_err_o !== 1'b0) begin
      bad++;
      $display("FAIL wait_forever_result got v=%0b res=%0d err=%0b want 1/18/0",
               out_valid_o, out_result_o, out_err_o);
    end
    step();
`endif
  endtask

  task automatic test_random;
    logic [36:0] q[$];
    bit pend = 1'b0;
    bit outv = 1'b0;
    bit acc;
    bit exp_ready;
    int bcnt = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid_i  = 1'($urandom_range(0, 1));
      in_data1_i  = $urandom;
      in_data2_i  = $urandom;
      in_op_i     = 4'($urandom_range(0, 4));
      in_rd_i     = 5'($urandom);
      out_ready_i = ($urandom_range(0, 3) != 0);
      ALU_busy_i  = (pend && bcnt >= 2) ? 1'b0 : 1'($urandom_range(0, 1));
      junk        = $urandom;
      #1;
      exp_ready = (!pend && !outv) || (outv && out_ready_i);
      total++;
      if (out_valid_o !== outv || in_ready_o !== exp_ready) begin
        bad++;
        $display("FAIL rand_hs c%0d got v=%0b rdy=%0b want %0b/%0b",
                 i, out_valid_o, in_ready_o, outv, exp_ready);
      end
      if (outv && q.size() > 0) begin
        total++;
        if (out_result_o !== q[0][31:0] || out_rd_o !== q[0][36:32] ||
            out_err_o !== 1'b0) begin
          bad++;
          $display("FAIL rand_data c%0d got res=%h rd=%0d err=%0b want %h/%0d/0",
                   i, out_result_o, out_rd_o, out_err_o, q[0][31:0], q[0][36:32]);
        end
      end
      acc = in_valid_i && exp_ready;
      if (outv && out_ready_i) begin
        void'(q.pop_front());
        outv = 1'b0;
      end
      if (pend) begin
        if (!ALU_busy_i) begin
          outv = 1'b1;
          pend = 1'b0;
          bcnt = 0;
        end else begin
          bcnt++;
        end
      end
      if (acc) begin
        q.push_back({in_rd_i, ref_alu(in_op_i, in_data1_i, in_data2_i)});
        pend = 1'b1;
      end
      step();
    end
    idle_inputs();
    repeat (4) step();
  endtask

  initial begin
    junk = 32'h0;
    test_reset();
    test_basic();
    test_wait();
    test_stall();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
